// File: rtl/lc3b_types.sv
// Shared LC-3b cache/memory types, including the eviction-buffer drain state.
package lc3b_types;

  typedef logic [127:0] lc3b_burst;
  typedef logic [11:0]  lc3b_tag;

  typedef enum logic {
    evb_idle  = 1'b0,
    evb_write = 1'b1
  } lc3b_evb_state;

  localparam int LC3B_LINE_OFFSET = 4;

endpackage

// File: rtl/lc3b_evict_buffer_if.sv
// Cache-side push/lookup and memory-side write handshake of the eviction buffer.
interface lc3b_evict_buffer_if #(
  parameter int TAG_WIDTH  = 12,
  parameter int LINE_WIDTH = 128,
  parameter int ADDR_WIDTH = 16
);

  logic                  push;
  logic [TAG_WIDTH-1:0]  push_tag;
  logic [LINE_WIDTH-1:0] push_line;
  logic                  full;
  logic                  empty;
  logic [TAG_WIDTH-1:0]  lookup_tag;
  logic                  hit;
  logic [LINE_WIDTH-1:0] hit_line;
  logic                  pmem_write;
  logic [ADDR_WIDTH-1:0] pmem_address;
  logic [LINE_WIDTH-1:0] pmem_wdata;
  logic                  pmem_resp;

  modport master (
    output push, push_tag, push_line, lookup_tag, pmem_resp,
    input  full, empty, hit, hit_line, pmem_write, pmem_address, pmem_wdata
  );

  modport slave (
    input  push, push_tag, push_line, lookup_tag, pmem_resp,
    output full, empty, hit, hit_line, pmem_write, pmem_address, pmem_wdata
  );

endinterface

// File: rtl/lc3b_evb_match.sv
// Combinational tag comparator: per-entry match vector and the index of the
// youngest match, scanning back from tail.
module lc3b_evb_match #(
  parameter int DEPTH     = 4,
  parameter int TAG_WIDTH = 12
) (
  input  logic [DEPTH-1:0][TAG_WIDTH-1:0] tags,
  input  logic [DEPTH-1:0]                valid,
  input  logic [TAG_WIDTH-1:0]            probe,
  input  logic [$clog2(DEPTH)-1:0]        tail,
  output logic [DEPTH-1:0]                match,
  output logic [$clog2(DEPTH)-1:0]        youngest
);

  localparam int PTR_W = $clog2(DEPTH);

  always_comb begin
    // NOTE: every combinational output gets a default before any conditional
    // assignment, otherwise synthesis infers a latch.
    match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = valid[i] && (tags[i] == probe);
    end
  end

  // Walk from oldest (age DEPTH) to youngest (age 1) so the last hit wins.
  always_comb begin
    youngest = '0;
    for (int age = DEPTH; age >= 1; age--) begin
      if (match[tail - PTR_W'(age)]) youngest = tail - PTR_W'(age);
    end
  end

endmodule

// File: rtl/lc3b_evict_buffer.sv
// Write-back eviction buffer: FIFO of dirty victim lines drained to physical
// memory, with same-cycle lookup. LC3B_EVB_COALESCE_EN merges same-tag pushes.
module lc3b_evict_buffer
  import lc3b_types::*;
#(
  parameter int DEPTH        = 4,
  parameter int TAG_WIDTH    = $bits(lc3b_tag),
  parameter int LINE_WIDTH   = $bits(lc3b_burst),
  parameter int OFFSET_WIDTH = LC3B_LINE_OFFSET
) (
  input logic               clk,
  input logic               reset,
  lc3b_evict_buffer_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0][TAG_WIDTH-1:0]  tag_q;
  logic [DEPTH-1:0][LINE_WIDTH-1:0] line_q;
  logic [DEPTH-1:0]                 valid_q;
  logic [PTR_W-1:0]                 head_q, tail_q;
  logic [CNT_W-1:0]                 count_q;
  lc3b_evb_state                    state_q, state_d;

  logic             full;
  logic             pop;
  logic             alloc;
  logic [DEPTH-1:0] look_match;
  logic [PTR_W-1:0] look_idx;

  assign full = (count_q == CNT_W'(DEPTH));
  assign pop  = (state_q == evb_write) && bus.pmem_resp;

  lc3b_evb_match #(.DEPTH(DEPTH), .TAG_WIDTH(TAG_WIDTH)) u_lookup_match (
    .tags     (tag_q),
    .valid    (valid_q),
    .probe    (bus.lookup_tag),
    .tail     (tail_q),
    .match    (look_match),
    .youngest (look_idx)
  );

`ifdef LC3B_EVB_COALESCE_EN
  logic [DEPTH-1:0] coal_valid;
  logic [DEPTH-1:0] coal_match;
  logic [PTR_W-1:0] coal_idx;
  logic             coalesce;

  // The head being written to memory is frozen; a same-tag push behind it
  // must become a new entry.
  always_comb begin
    coal_valid = valid_q;
    if (state_q == evb_write) coal_valid[head_q] = 1'b0;
  end

  lc3b_evb_match #(.DEPTH(DEPTH), .TAG_WIDTH(TAG_WIDTH)) u_coal_match (
    .tags     (tag_q),
    .valid    (coal_valid),
    .probe    (bus.push_tag),
    .tail     (tail_q),
    .match    (coal_match),
    .youngest (coal_idx)
  );

  assign coalesce = bus.push && (|coal_match);
  assign alloc    = bus.push && !(|coal_match) && !full;
`else
  assign alloc = bus.push && !full;
`endif

  // Control state: pointers, count and valid bits.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      if (alloc) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + 1'b1;
      end
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      case ({alloc, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: the tag/line storage is deliberately not reset; valid_q alone
  // decides whether an entry is meaningful, which keeps the array RAM-friendly.
  always_ff @(posedge clk) begin
    if (alloc) begin
      tag_q[tail_q]  <= bus.push_tag;
      line_q[tail_q] <= bus.push_line;
    end
`ifdef LC3B_EVB_COALESCE_EN
    else if (coalesce) begin
      line_q[coal_idx] <= bus.push_line;
    end
`endif
  end

  // Drain FSM: state register, next-state logic, outputs.
  always_ff @(posedge clk) begin
    if (reset) state_q <= evb_idle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      evb_idle:  if (count_q != '0)  state_d = evb_write;
      evb_write: if (bus.pmem_resp)  state_d = evb_idle;
      default:                       state_d = evb_idle;
    endcase
  end

  always_comb begin
    bus.pmem_write   = 1'b0;
    bus.pmem_address = '0;
    bus.pmem_wdata   = '0;
    if (state_q == evb_write) begin
      bus.pmem_write   = 1'b1;
      bus.pmem_address = {tag_q[head_q], {OFFSET_WIDTH{1'b0}}};
      bus.pmem_wdata   = line_q[head_q];
    end
  end

  assign bus.full     = full;
  assign bus.empty    = (count_q == '0);
  assign bus.hit      = |look_match;
  assign bus.hit_line = (|look_match) ? line_q[look_idx] : '0;

endmodule

// File: tb/tb_lc3b_evict_buffer.sv
// Self-checking bench for lc3b_evict_buffer: queue-based reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_lc3b_evict_buffer;

  localparam int DEPTH = 4;
  localparam int TW    = 12;
  localparam int LW    = 128;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lc3b_evict_buffer_if #(.TAG_WIDTH(TW), .LINE_WIDTH(LW)) bus ();

  lc3b_evict_buffer #(
    .DEPTH(DEPTH), .TAG_WIDTH(TW), .LINE_WIDTH(LW), .OFFSET_WIDTH(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of pending lines, oldest at index 0.
  typedef struct packed {
    logic [TW-1:0] tag;
    logic [LW-1:0] line;
  } ent_t;

  ent_t q[$];
  bit   writing = 1'b0;
  bit   cmp_en  = 1'b0;

  always @(posedge clk) begin : model
    int   sz;
    bit   was_full;
    bit   pop;
    bit   do_alloc;
`ifdef LC3B_EVB_COALESCE_EN
    int   hit_i;
    ent_t e;
`endif
    if (reset) begin
      q.delete();
      writing = 1'b0;
      cmp_en  = 1'b1;
    end else begin
      sz       = q.size();
      was_full = (sz == DEPTH);
      pop      = writing && bus.pmem_resp;
      do_alloc = 1'b0;
      if (bus.push) begin
`ifdef LC3B_EVB_COALESCE_EN
        hit_i = -1;
        for (int i = sz - 1; i >= (writing ? 1 : 0); i--) begin
          if (hit_i < 0 && q[i].tag == bus.push_tag) hit_i = i;
        end
        if (hit_i >= 0) begin
          e      = q[hit_i];
          e.line = bus.push_line;
          q[hit_i] = e;
        end else begin
          do_alloc = !was_full;
        end
`else
        do_alloc = !was_full;
`endif
      end
      writing = writing ? !bus.pmem_resp : (sz > 0);
      if (pop) void'(q.pop_front());
      if (do_alloc) q.push_back('{tag: bus.push_tag, line: bus.push_line});
    end
  end

  always @(negedge clk) begin : compare
    logic          exp_hit;
    logic [LW-1:0] exp_line;
    if (cmp_en) begin
      exp_hit  = 1'b0;
      exp_line = '0;
      for (int i = 0; i < q.size(); i++) begin
        if (q[i].tag == bus.lookup_tag) begin
          exp_hit  = 1'b1;
          exp_line = q[i].line;
        end
      end
      check("m_full",       bus.full,       q.size() == DEPTH);
      check("m_empty",      bus.empty,      q.size() == 0);
      check("m_hit",        bus.hit,        exp_hit);
      check("m_hit_line",   bus.hit_line,   exp_line);
      check("m_pmem_write", bus.pmem_write, writing);
      if (writing && q.size() > 0) begin
        check("m_pmem_address", bus.pmem_address, {q[0].tag, 4'h0});
        check("m_pmem_wdata",   bus.pmem_wdata,   q[0].line);
      end
    end
  end

  function automatic logic [LW-1:0] line_of(input logic [TW-1:0] tag);
    return {8{4'h0, tag}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_push(input logic [TW-1:0] tag, input logic [LW-1:0] line);
    bus.push      = 1'b1;
    bus.push_tag  = tag;
    bus.push_line = line;
    tick();
    bus.push = 1'b0;
  endtask

  task automatic wait_write(input string name);
    int n;
    n = 0;
    while (!bus.pmem_write && n < 20) begin
      tick();
      n++;
    end
    check(name, bus.pmem_write, 1'b1);
  endtask

  task automatic drain_one(input string name, input logic [15:0] addr, input logic [LW-1:0] data);
    wait_write({name, "_write"});
    check({name, "_addr"}, bus.pmem_address, addr);
    check({name, "_data"}, bus.pmem_wdata, data);
    bus.pmem_resp = 1'b1;
    tick();
    bus.pmem_resp = 1'b0;
  endtask

  initial begin : global_timeout
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin : stimulus
    logic [LW-1:0] data_a;
    logic [LW-1:0] data_b;
    data_a = {32{4'hA}};
    data_b = {32{4'hB}};

    bus.push       = 1'b0;
    bus.push_tag   = '0;
    bus.push_line  = '0;
    bus.lookup_tag = '0;
    bus.pmem_resp  = 1'b0;
    reset          = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // Reset state, then idle cycles.
    check("rst_address",  bus.pmem_address, 16'h0000);
    check("rst_wdata",    bus.pmem_wdata,   '0);
    check("rst_hit",      bus.hit,          1'b0);
    check("rst_hit_line", bus.hit_line,     '0);
    repeat (3) begin
      tick();
      check("idle_empty", bus.empty,      1'b1);
      check("idle_full",  bus.full,       1'b0);
      check("idle_write", bus.pmem_write, 1'b0);
    end

    // Single line; a resp while idle is ignored.
    bus.lookup_tag = 12'h0A3;
    bus.pmem_resp  = 1'b1;
    do_push(12'h0A3, {32{4'h1}});
    bus.pmem_resp = 1'b0;
    check("one_hit",      bus.hit,      1'b1);
    check("one_hit_line", bus.hit_line, {32{4'h1}});
    check("one_empty",    bus.empty,    1'b0);
    wait_write("one_rise");
    check("one_addr", bus.pmem_address, 16'h0A30);
    repeat (2) begin
      tick();
      check("one_hold_write", bus.pmem_write,   1'b1);
      check("one_hold_addr",  bus.pmem_address, 16'h0A30);
      check("one_hold_data",  bus.pmem_wdata,   {32{4'h1}});
    end
    bus.pmem_resp = 1'b1;
    tick();
    bus.pmem_resp = 1'b0;
    check("one_done_write", bus.pmem_write, 1'b0);
    check("one_done_empty", bus.empty,      1'b1);

    // Fill to DEPTH with memory stalled; the fifth push is dropped.
    bus.lookup_tag = 12'h005;
    for (int t = 1; t <= 4; t++) do_push(TW'(t), line_of(TW'(t)));
    check("fill_full", bus.full, 1'b1);
    do_push(12'h005, line_of(12'h005));
    check("fill_full_after_drop", bus.full, 1'b1);
    check("fill_drop_no_hit",     bus.hit,  1'b0);
    drain_one("fill_d1", 16'h0010, line_of(12'h001));
    drain_one("fill_d2", 16'h0020, line_of(12'h002));
    drain_one("fill_d3", 16'h0030, line_of(12'h003));
    drain_one("fill_d4", 16'h0040, line_of(12'h004));
    check("fill_empty", bus.empty, 1'b1);

    // Duplicate tag pushed twice while draining is stalled.
    bus.lookup_tag = 12'h050;
    do_push(12'h050, data_a);
    do_push(12'h050, data_b);
    check("dup_hit",      bus.hit,      1'b1);
    check("dup_hit_line", bus.hit_line, data_b);
`ifdef LC3B_EVB_COALESCE_EN
    drain_one("dup_d1", 16'h0500, data_b);
    check("dup_empty_after_one", bus.empty, 1'b1);
`else
    drain_one("dup_d1", 16'h0500, data_a);
    check("dup_empty_after_one", bus.empty, 1'b0);
    drain_one("dup_d2", 16'h0500, data_b);
`endif
    check("dup_empty", bus.empty, 1'b1);

    // Push coinciding with resp, across 2*DEPTH pointer steps.
    bus.lookup_tag = 12'h104;
    do_push(12'h100, line_of(12'h100));
    for (int i = 1; i <= 2 * DEPTH; i++) begin
      wait_write("wrap_write");
      check("wrap_addr", bus.pmem_address, {TW'(12'h100 + i - 1), 4'h0});
      bus.push      = 1'b1;
      bus.push_tag  = TW'(12'h100 + i);
      bus.push_line = line_of(TW'(12'h100 + i));
      bus.pmem_resp = 1'b1;
      tick();
      bus.push      = 1'b0;
      bus.pmem_resp = 1'b0;
      check("wrap_write_low", bus.pmem_write, 1'b0);
      check("wrap_not_empty", bus.empty,      1'b0);
    end
    drain_one("wrap_last", 16'h1080, line_of(12'h108));
    check("wrap_empty", bus.empty, 1'b1);

    // Reset while a write is outstanding with three lines queued.
    bus.lookup_tag = 12'h0C1;
    do_push(12'h0C1, line_of(12'h0C1));
    do_push(12'h0C2, line_of(12'h0C2));
    do_push(12'h0C3, line_of(12'h0C3));
    wait_write("rstmid_write");
    check("rstmid_addr", bus.pmem_address, 16'h0C10);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstmid_write_low", bus.pmem_write, 1'b0);
    check("rstmid_empty",     bus.empty,      1'b1);
    check("rstmid_no_hit",    bus.hit,        1'b0);
    bus.lookup_tag = 12'h0FF;
    do_push(12'h0FF, line_of(12'h0FF));
    drain_one("rstmid_after", 16'h0FF0, line_of(12'h0FF));
    check("rstmid_final_empty", bus.empty, 1'b1);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lc3b_evict_buffer.md
Name: lc3b_evict_buffer

Overview:
- Parametrised write-back eviction buffer between the LC-3b cache and physical memory.
- Accepts dirty victim lines (one lc3b_burst plus line tag) from the cache in one cycle.
- Queues them FIFO and drains them to memory through a write handshake.
- Provides a same-cycle lookup so the cache can serve a miss from a line still waiting for write-back.

Parameters:
- DEPTH, 4, number of line entries (power of two, at least 2).
- TAG_WIDTH, 12, line-address width (lc3b_tag); memory byte address = {tag, OFFSET_WIDTH zeros}.
- LINE_WIDTH, 128, bits per line (lc3b_burst).
- OFFSET_WIDTH, 4, byte-offset bits within a line; TAG_WIDTH + OFFSET_WIDTH = 16.

Ports:
- clk  in  1  clock, all state updates on the rising edge
- reset  in  1  synchronous, active-high
- push  in  1  enqueue a victim line this cycle
- push_tag  in  TAG_WIDTH  line address of the victim
- push_line  in  LINE_WIDTH  victim data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- lookup_tag  in  TAG_WIDTH  line address probed by a cache miss
- hit  out  1  some valid entry matches lookup_tag (combinational)
- hit_line  out  LINE_WIDTH  data of the youngest matching entry; 0 when hit = 0
- pmem_write  out  1  memory write request
- pmem_address  out  16  {head tag, zeros}
- pmem_wdata  out  LINE_WIDTH  head entry data
- pmem_resp  in  1  memory write complete

Behaviour:
- Storage: circular array with head/tail pointers of clog2(DEPTH) bits and a count of clog2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
- Reset (synchronous, active-high): count=0, head=tail=0, all valid bits cleared, FSM to IDLE. Resulting outputs: full=0, empty=1, pmem_write=0, pmem_address=0, pmem_wdata=0, hit=0, hit_line=0.
- Reset mid-drain: the write is abandoned and pmem_write is low in the cycle after reset. Queued lines are lost.
- Push acceptance: push accepted iff !full. A push while full is dropped with no state change, even if a pop occurs in the same cycle.
- Accepted push: writes the entry at tail, sets its valid bit, increments tail. The entry is visible to lookup on the next cycle (one-cycle latency).
- Drain FSM, IDLE: if count > 0, go to WRITE.
- Drain FSM, WRITE: pmem_write=1, and pmem_address/pmem_wdata are driven from head, held stable. On pmem_resp: clear head valid, increment head, decrement count, return to IDLE. This gives one idle cycle between consecutive writes.
- pmem_write depends only on registered state and is never combinational on pmem_resp.
- Simultaneous push and pop (not full): both take effect, count unchanged.
- pmem_resp while in IDLE: ignored.
- Lookup: purely combinational compare against all valid entries. If several entries match, the youngest (closest to tail) wins. The head entry under drain is included.
- Cache contract: the cache must not push while lookup is being consumed for the same tag in the same cycle.

Optional Feature:
- Macro: LC3B_EVB_COALESCE_EN.
- Defined: a push whose tag matches a valid entry that is not the head currently in WRITE overwrites that entry's data in place. No new entry is allocated, count and tail are unchanged, and the push is accepted even when full. A match against the head in WRITE allocates a new entry as normal.
- Undefined: every accepted push allocates a new entry, duplicates are allowed, and lookup youngest-match resolves them.

Decomposition:
- lc3b_types gains:
  - typedef enum lc3b_evb_state {evb_idle, evb_write}
  - localparam LC3B_LINE_OFFSET = 4
- Reused from lc3b_types: lc3b_burst, lc3b_tag.
- One natural sub-module, lc3b_evb_match: a combinational tag comparator returning a DEPTH-bit match vector plus the youngest-match index given tail. It is shared by lookup and coalesce logic.

Test Plan:
- Reset then idle → empty=1, full=0, pmem_write=0 on every cycle.
- Push tag 0x0A3 with data 0x1111...1111; pmem_resp returned 3 cycles after pmem_write rises → pmem_address=0x0A30, wdata matches, pmem_write held until resp, empty=1 one cycle after resp.
- 4 pushes (tags 0x001–0x004) with pmem_resp held low → full=1. A fifth push (0x005) is dropped. Draining afterwards produces addresses 0x0010, 0x0020, 0x0030, 0x0040 in that order.
- Push 0x050 with data A, then 0x050 with data B, while draining is stalled → with macro undefined, count=2 and lookup 0x050 gives hit=1, hit_line=B. With macro defined, count=1 and hit_line=B.
- Push while head is in WRITE with pmem_resp in the same cycle → count unchanged and head/tail wrap correctly across 2×DEPTH operations.
- Assert reset while pmem_write=1 with 3 entries queued → next cycle pmem_write=0, empty=1; a later push of 0x0FF drains normally.
